// File: rtl/arm_fetch.sv
// arm_fetch -- instruction fetch stage feeding decode.
//
// Keeps the fetch PC, drives it onto the arm_memory read port (synchronous,
// one-cycle read latency), captures returned words into a circular prefetch
// buffer and presents the buffer head to decode via valid/ready. A branch
// redirect empties the buffer and discards any in-flight return.
//
// Optional feature: define ARM_FETCH_PERF_EN to add the perf_delivered and
// perf_flushed counter ports.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   mem_addr                   read address (always the fetch PC register)
//   mem_data, mem_excpt        read data / exception, valid the cycle after the address edge
//   branch_valid, branch_target redirect pulse and target
//   inst_valid, inst_ready     head handshake with decode
//   inst, inst_pc, inst_excpt  head word, its fetch address, its exception flag
//   perf_delivered, perf_flushed  (ARM_FETCH_PERF_EN only) pops / redirect-discarded words
//
// States:
//   S_FETCH  | normal operation, fetches issued while the buffer has room
//   S_HALTED | an exception word was captured; no issue until a redirect
module arm_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_excpt,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_excpt
`ifdef ARM_FETCH_PERF_EN
  ,
  output logic [31:0] perf_delivered,
  output logic [31:0] perf_flushed
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {S_FETCH, S_HALTED} state_t;

  state_t          state, state_nxt;
  logic [31:0]     fetch_pc;
  logic [31:0]     inflight_pc;
  logic            inflight;
  logic [31:0]     fifo_data  [DEPTH];
  logic            fifo_excpt [DEPTH];
  logic [31:0]     fifo_pc    [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            pop, issue, capture;
  logic [CW:0]     occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign mem_addr   = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst       = fifo_data[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];
  assign inst_excpt = fifo_excpt[rd_ptr];
  assign pop        = inst_valid & inst_ready;

  // Slots committed after this edge: buffered + returning word - leaving word.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    if (branch_valid) begin
      state_nxt = S_FETCH;
    end else begin
      // Once halted, the word issued alongside the faulting capture is
      // dropped on return so nothing follows the exception entry.
      capture = inflight && (state == S_FETCH);
      issue   = (state == S_FETCH) && (occupancy < (CW+1)'(DEPTH));
      if (capture && mem_excpt)
        state_nxt = S_HALTED;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i]  <= '0;
        fifo_excpt[i] <= 1'b0;
        fifo_pc[i]    <= '0;
      end
    end else if (branch_valid) begin
      fetch_pc <= branch_target;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      // Every in-flight word returns the next cycle, so inflight simply
      // tracks whether an issue happened this edge.
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      if (capture) begin
        fifo_data[wr_ptr]  <= mem_data;
        fifo_excpt[wr_ptr] <= mem_excpt;
        fifo_pc[wr_ptr]    <= inflight_pc;
        wr_ptr             <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({capture, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ARM_FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_delivered <= '0;
      perf_flushed   <= '0;
    end else begin
      if (pop)
        perf_delivered <= perf_delivered + 32'd1;
      // The popped word is delivered, not flushed.
      if (branch_valid)
        perf_flushed <= perf_flushed + 32'(count) - 32'(pop) + 32'(inflight);
    end
  end
`endif

endmodule

// File: tb/tb_arm_fetch.sv
module tb_arm_fetch;

  localparam logic [31:0] RPC      = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] EXC_ADDR = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic        mem_excpt = 1'b0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_excpt;
`ifdef ARM_FETCH_PERF_EN
  logic [31:0] perf_delivered, perf_flushed;
`endif

  arm_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_excpt(mem_excpt),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_excpt(inst_excpt)
`ifdef ARM_FETCH_PERF_EN
    , .perf_delivered(perf_delivered), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hE3A0_0001;
      32'h4:   return 32'hE3A0_1002;
      32'h8:   return 32'hE080_2001;
      default: return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  function automatic logic mem_exc(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a == EXC_ADDR);
  endfunction

  // Synchronous-read memory: address at edge E is visible during the next cycle.
  always @(posedge clk) begin
    mem_data  <= mem_word(mem_addr);
    mem_excpt <= mem_exc(mem_addr);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic        exc;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  bit          pend;
  logic [31:0] pend_pc;
  logic [31:0] next_pc;
  bit          halted;
  logic [31:0] deliv, flushed;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend = 0; pend_pc = '0; next_pc = RPC; halted = 0;
    deliv = '0; flushed = '0;
  endtask

  task automatic model_check();
    chk("valid", 32'(inst_valid), 32'(q.size() != 0));
    chk("mem_addr", mem_addr, next_pc);
    if (q.size() != 0) begin
      chk("inst", inst, q[0].data);
      chk("inst_pc", inst_pc, q[0].pc);
      chk("inst_excpt", 32'(inst_excpt), 32'(q[0].exc));
    end
`ifdef ARM_FETCH_PERF_EN
    chk("perf_delivered", perf_delivered, deliv);
    chk("perf_flushed", perf_flushed, flushed);
`endif
  endtask

  task automatic model_step(input bit rdy, input bit br, input logic [31:0] tgt);
    bit pop;
    bit iss;
    ent_t e;
    pop = (q.size() != 0) && rdy;
    if (pop) deliv = deliv + 1;
    if (br) begin
      flushed = flushed + 32'(q.size()) - 32'(pop) + 32'(pend);
      q.delete();
      pend = 0;
      next_pc = tgt;
      halted = 0;
    end else begin
      iss = !halted && ((q.size() + int'(pend) - int'(pop)) < DEPTH);
      if (pop) void'(q.pop_front());
      if (pend && !halted) begin
        e.data = mem_word(pend_pc);
        e.exc  = mem_exc(pend_pc);
        e.pc   = pend_pc;
        q.push_back(e);
        if (e.exc) halted = 1;
      end
      pend = iss;
      if (iss) begin
        pend_pc = next_pc;
        next_pc = next_pc + 32'd4;
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic finish_cycle();
    model_check();
    model_step(inst_ready, branch_valid, branch_target);
    @(negedge clk);
  endtask

  task automatic cyc(input bit rdy, input bit br, input logic [31:0] tgt);
    inst_ready    = rdy;
    branch_valid  = br;
    branch_target = tgt;
    #1;
    finish_cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inst_ready = 1'b0; branch_valid = 1'b0; branch_target = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          ready;
    bit          v;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[5];

  task automatic run_table();
    for (int i = 0; i < 5; i++) begin
      inst_ready   = tbl[i].ready;
      branch_valid = 1'b0;
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_inst", i), inst, tbl[i].inst);
      chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
      finish_cycle();
    end
  endtask

  initial begin
    logic [31:0] tgt;
    tbl[0] = '{1'b1, 1'b0, 32'h0,          32'h0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h0,          32'h0, 32'h4};
    tbl[2] = '{1'b1, 1'b1, 32'hE3A0_0001,  32'h0, 32'h8};
    tbl[3] = '{1'b1, 1'b1, 32'hE3A0_1002,  32'h4, 32'hC};
    tbl[4] = '{1'b1, 1'b1, 32'hE080_2001,  32'h8, 32'h10};

    model_reset();
    @(negedge clk);
    do_reset();
    run_table();

    // Stall from reset: buffer fills to DEPTH, address parks at 0x10.
    do_reset();
    repeat (10) cyc(0, 0, '0);
    chk("stall_addr", mem_addr, 32'h10);
    chk("stall_valid", 32'(inst_valid), 32'h1);
    repeat (8) cyc(1, 0, '0);

    // Redirect with a full buffer.
    repeat (8) cyc(0, 0, '0);
    cyc(0, 1, 32'h40);
    cyc(1, 0, '0);
    cyc(1, 0, '0);
    #1;
    chk("redir_pc", inst_pc, 32'h40);
    chk("redir_valid", 32'(inst_valid), 32'h1);
    repeat (4) cyc(1, 0, '0);

    // Exception at 0x1000 halts fetch.
    cyc(1, 1, 32'hFF8);
    repeat (12) cyc(1, 0, '0);
    #1;
    chk("halt_valid", 32'(inst_valid), 32'h0);
    cyc(1, 1, 32'h0);
    repeat (5) cyc(1, 0, '0);

    // Misaligned redirect.
    cyc(0, 1, 32'h42);
    cyc(0, 0, '0);
    cyc(0, 0, '0);
    #1;
    chk("mis_pc", inst_pc, 32'h42);
    chk("mis_excpt", 32'(inst_excpt), 32'h1);
    repeat (6) cyc(1, 0, '0);
    #1;
    chk("mis_halt", 32'(inst_valid), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0:       tgt = 32'hFF0;
        1:       tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        2:       tgt = {20'h0, 12'($urandom_range(0, 4095))};
        3:       tgt = 32'hFFFF_FFF8;
        default: tgt = {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
      endcase
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt);
    end

    // Asynchronous reset between edges, then restart.
    inst_ready = 1'b1; branch_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(inst_valid), 32'h0);
    chk("async_addr", mem_addr, RPC);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_table();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
